axis_frame_tx: RTL and testbench
================================

Name: axis_frame_tx

Overview:
- AXI-Stream frame transmitter: the source end of the stream interface our pipeline-register chains carry.
- Takes a frame command (beat count, last-beat keep, user) plus a raw, unframed word stream.
- Emits a framed AXI-Stream with tdata/tkeep/tlast/tuser through a registered skid output stage.
- Sits in front of the accelerator's stream pipelines, e.g. the DMA-to-engine path, so downstream logic sees correctly delimited frames.

Parameters:
DATA_WIDTH, 8, tdata width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep width in bytes
USER_WIDTH, 1, tuser width
LEN_WIDTH, 16, width of cmd_len (frame length in beats minus one)
CNT_WIDTH, 32, width of the completed-frame counter

Ports:
clk  in  1  clock; all logic is on the rising edge
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  frame command valid
cmd_ready  out  1  frame command ready
cmd_len  in  LEN_WIDTH  frame length minus one (0 means a 1-beat frame)
cmd_keep_last  in  KEEP_WIDTH  tkeep for the final beat
cmd_user  in  USER_WIDTH  tuser for every beat of the frame
s_data  in  DATA_WIDTH  raw word input
s_valid  in  1  raw word valid
s_ready  out  1  raw word ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  KEEP_WIDTH  stream byte enables
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last beat of frame
m_axis_tuser  out  USER_WIDTH  stream user
busy  out  1  frame in progress or output stage non-empty
frame_count  out  CNT_WIDTH  completed frames (tlast handshakes on m_axis)

Behaviour:
- One clock; reset is asynchronous, active-low (rstn), applied to all state.
- Reset values:
  - cmd_ready=0, s_ready=0, m_axis_tvalid=0.
  - m_axis_tdata/tkeep/tlast/tuser=0.
  - busy=0, frame_count=0.
  - FSM in IDLE, beat counter 0, skid buffer empty.
- cmd_ready is registered. It rises on the first clock edge after rstn deasserts and is 1 whenever the FSM is in IDLE.
- FSM states:
  - IDLE: cmd_ready=1, s_ready=0. On cmd_valid&cmd_ready, latch cmd_len into the down-counter rem, latch keep_last and user, and go to STREAM.
  - STREAM: cmd_ready=0. s_ready=1 when the skid stage can accept a beat. Each s_valid&s_ready pushes one beat into the output stage:
    - tlast = (rem==0).
    - tkeep = latched keep_last when rem==0, else all ones.
    - tuser = latched user.
    - rem decrements on each push.
    - The push with rem==0 returns the FSM to IDLE.
- A cmd_keep_last of 0 is replaced by all ones at latch time.
- Frame gap: one idle input cycle between frames (cmd_ready returns the cycle after the last push). Within a frame, throughput is 1 beat/clk while m_axis_tready=1.
- Latency: a beat accepted on s_* at edge t is presented on m_axis_* after edge t, i.e. 1 cycle.
- Output stage is a 2-entry skid buffer. m_axis_* are driven only from flops.
  - Internal ready is registered: it deasserts when the buffer holds 1 beat and a stall occurs.
  - No beat is ever dropped or duplicated.
  - While m_axis_tvalid=1 and m_axis_tready=0, tdata/tkeep/tlast/tuser hold stable.
- s_valid in IDLE is ignored; no data is consumed.
- frame_count increments on m_axis_tvalid&m_axis_tready&m_axis_tlast and wraps modulo 2^CNT_WIDTH.
- busy = (state==STREAM) | skid buffer non-empty.
- Reset mid-frame: the partial frame is discarded, no tlast is emitted, the output goes invalid asynchronously, and the command must be reissued.
- cmd_len at its maximum (2^LEN_WIDTH-1) gives 2^LEN_WIDTH beats with no counter overflow.

Decomposition:
- Shared package axis_frame_pkg:
  - FSM state enum (IDLE, STREAM).
  - Skid beat struct {data, keep, last, user}.
  - Constant KEEP_ALL.
- Sub-module axis_frame_tx_skid: 2-entry skid buffer with registered ready, holding the beat struct. Top level holds the FSM, counter and frame counter.

Test Plan:
- Reset then cmd_len=3, keep_last=0x1 (DATA_WIDTH=16, KEEP_WIDTH=2), user=1, data 0xA0..0xA3, m_ready=1 → 4 beats on consecutive cycles. tkeep=3,3,3,1; tlast only on 0xA3; tuser=1 throughout; frame_count=1.
- cmd_len=0, keep_last=0 → single beat with tlast=1 and tkeep=all ones; FSM returns to IDLE; cmd_ready=1 two cycles after the command.
- 8-beat frame with m_axis_tready toggling 1010… and s_valid constant → all 8 beats delivered in order with no drop or duplicate. Outputs hold stable during stalls; s_ready never stays high when 2 beats are buffered.
- Back-to-back commands len 1 then len 2 with continuous data → 5 beats, tlast on beats 2 and 5, exactly one idle input cycle between frames, frame_count=2.
- rstn asserted after beat 2 of a 6-beat frame → m_axis_tvalid=0 immediately. After release, cmd_ready=1 on the next edge and frame_count=0.
- frame_count preset via 2^CNT_WIDTH frames (CNT_WIDTH=4: 16 one-beat frames) → wraps to 0.

Source files
------------

// File: rtl/axis_frame_pkg.sv
// Shared definitions for the AXI-Stream frame transmitter.
// Contents:
//   state_t  - frame FSM state (IDLE waits for a command, STREAM forwards beats)
//   KEEP_MAX - widest tkeep the transmitter supports
//   KEEP_ALL - all-ones byte enable, sliced to KEEP_WIDTH by users
// The beat struct is declared inside axis_frame_tx, because its field widths
// follow that module's parameters.
package axis_frame_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int KEEP_MAX = 128;
  localparam logic [KEEP_MAX-1:0] KEEP_ALL = {KEEP_MAX{1'b1}};

endpackage

// File: rtl/axis_frame_tx_skid.sv
// Two-entry skid buffer with a registered input ready.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   in_data/in_valid - beat being pushed (in_valid must already include in_ready)
//   in_ready         - registered: low only while the skid entry is occupied
//   out_data/out_valid/out_ready - registered downstream handshake
//   empty            - no beat held in either entry
// A pushed beat goes straight to the output register whenever that register
// is free or draining, so the latency is one cycle. The skid entry only catches
// the beat that arrives during a stall; while it is occupied, in_ready is low.
module axis_frame_tx_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty
);

  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             out_valid_r;
  logic             skid_valid_r;
  logic             in_ready_r;
  logic             out_free_s;

  // The output register can take a new beat when it is empty or being consumed.
  assign out_free_s = out_ready | ~out_valid_r;

  // Output register, skid entry and registered ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data_r   <= {WIDTH{1'b0}};
      skid_data_r  <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (in_ready_r) begin
      if (out_free_s) begin
        out_valid_r <= in_valid;
        if (in_valid) begin
          out_data_r <= in_data;
        end else begin
          out_data_r <= out_data_r;
        end
      end else if (in_valid) begin
        // Stall with a beat already on the output: park the new one.
        skid_data_r  <= in_data;
        skid_valid_r <= 1'b1;
        in_ready_r   <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end else if (out_ready) begin
      // The output beat is consumed; the parked beat moves up and the output stays valid.
      out_data_r   <= skid_data_r;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign empty     = ~out_valid_r & ~skid_valid_r;

endmodule

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter. Each frame command (beat count minus one,
// last-beat keep, user) is combined with raw words to form a delimited frame.
// Ports:
//   clk, rstn                            - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                  - frame command handshake (cmd_ready registered)
//   cmd_len, cmd_keep_last, cmd_user     - frame length-1, final-beat tkeep, tuser
//   s_data/s_valid/s_ready               - raw unframed word input
//   m_axis_tdata/tkeep/tvalid/tready/tlast/tuser - framed output (all from flops)
//   busy                                 - frame in progress or output stage non-empty
//   frame_count                          - count of tlast handshakes, wraps
module axis_frame_tx
  import axis_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [KEEP_WIDTH-1:0] cmd_keep_last,
  input  logic [USER_WIDTH-1:0] cmd_user,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);
  localparam logic [KEEP_WIDTH-1:0] KEEP_FULL = KEEP_ALL[KEEP_WIDTH-1:0];

  state_t                state_r;
  logic                  cmd_ready_r;
  logic [LEN_WIDTH-1:0]  rem_r;
  logic [KEEP_WIDTH-1:0] keep_r;
  logic [USER_WIDTH-1:0] user_r;
  logic [CNT_WIDTH-1:0]  frame_count_r;

  logic                  last_s;
  logic                  push_s;
  logic [KEEP_WIDTH-1:0] keep_in_s;
  beat_t                 beat_in_s;
  beat_t                 beat_out_s;
  logic                  skid_ready_s;
  logic                  skid_empty_s;
  logic                  out_valid_s;
  logic                  tlast_hs_s;

  assign last_s  = (rem_r == {LEN_WIDTH{1'b0}});
  assign s_ready = (state_r == STREAM) & skid_ready_s;
  assign push_s  = s_valid & s_ready;

  // A zero last-beat keep would describe an empty beat, so it is promoted to all ones.
  always_comb begin
    keep_in_s = cmd_keep_last;
    if (cmd_keep_last == {KEEP_WIDTH{1'b0}}) begin
      keep_in_s = KEEP_FULL;
    end else begin
      keep_in_s = cmd_keep_last;
    end
  end

  // Beat presented to the output stage for the current push.
  always_comb begin
    beat_in_s.data = s_data;
    beat_in_s.last = last_s;
    beat_in_s.user = user_r;
    beat_in_s.keep = KEEP_FULL;
    if (last_s) begin
      beat_in_s.keep = keep_r;
    end else begin
      beat_in_s.keep = KEEP_FULL;
    end
  end

  // Frame FSM: command latch, remaining-beat down-counter and registered cmd_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      rem_r       <= {LEN_WIDTH{1'b0}};
      keep_r      <= {KEEP_WIDTH{1'b0}};
      user_r      <= {USER_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          cmd_ready_r <= 1'b1;
          if (cmd_valid && cmd_ready_r) begin
            rem_r       <= cmd_len;
            keep_r      <= keep_in_s;
            user_r      <= cmd_user;
            cmd_ready_r <= 1'b0;
            state_r     <= STREAM;
          end
        end
        STREAM: begin
          cmd_ready_r <= 1'b0;
          if (push_s) begin
            if (last_s) begin
              // cmd_ready returns together with IDLE, leaving one idle input cycle.
              cmd_ready_r <= 1'b1;
              state_r     <= IDLE;
            end else begin
              rem_r <= rem_r - LEN_WIDTH'(1);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b0;
        end
      endcase
    end
  end

  axis_frame_tx_skid #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (beat_in_s),
    .in_valid  (push_s),
    .in_ready  (skid_ready_s),
    .out_data  (beat_out_s),
    .out_valid (out_valid_s),
    .out_ready (m_axis_tready),
    .empty     (skid_empty_s)
  );

  assign tlast_hs_s = out_valid_s & m_axis_tready & beat_out_s.last;

  // Completed-frame counter, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_count_r <= {CNT_WIDTH{1'b0}};
    end else if (tlast_hs_s) begin
      frame_count_r <= frame_count_r + CNT_WIDTH'(1);
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign m_axis_tdata  = beat_out_s.data;
  assign m_axis_tkeep  = beat_out_s.keep;
  assign m_axis_tlast  = beat_out_s.last;
  assign m_axis_tuser  = beat_out_s.user;
  assign m_axis_tvalid = out_valid_s;
  assign busy          = (state_r == STREAM) | ~skid_empty_s;
  assign frame_count   = frame_count_r;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx (DATA_WIDTH=16, CNT_WIDTH=4). Expected beats
// are queued when a frame is driven and checked as they leave m_axis.
module tb_axis_frame_tx;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int UW = 1;
  localparam int LW = 16;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [KW-1:0] cmd_keep_last = '0;
  logic [UW-1:0] cmd_user = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic          busy;
  logic [CW-1:0] frame_count;

  exp_t sb[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_frames = 0;
  int   tready_mode = 0;

  axis_frame_tx #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .USER_WIDTH (UW),
    .LEN_WIDTH  (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_keep_last (cmd_keep_last),
    .cmd_user      (cmd_user),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: constant 1 or toggling every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tready_mode == 1) m_tready = ~m_tready;
      else m_tready = 1'b1;
    end
  end

  // Output monitor: scoreboard pop on every handshake, hold check during stalls.
  initial begin
    exp_t          e;
    logic [19:0]   obs;
    logic [19:0]   held;
    logic          stall_q;
    stall_q = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      obs = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (!rstn) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", 64'(m_tvalid), 64'(1));
          check("hold_beat", 64'(obs), 64'(held));
        end
        if (m_tvalid && m_tready) begin
          hs_cyc.push_back(cyc);
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: observed 0x%0h expected no beat", obs);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("beat", 64'(obs), 64'(e));
          end
        end
        stall_q = m_tvalid & ~m_tready;
        held = obs;
      end
    end
  end

  task automatic issue_cmd(input int len, input logic [KW-1:0] keep, input logic [UW-1:0] user);
    int w;
    cmd_valid = 1'b1;
    cmd_len = LW'(len);
    cmd_keep_last = keep;
    cmd_user = user;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [KW-1:0] keep, input logic [UW-1:0] user,
                            input logic [DW-1:0] base, input bit full_rate);
    exp_t          e;
    logic [KW-1:0] kfix;
    logic          rdy;
    int            i;
    int            cycles;
    kfix = (keep == 2'b00) ? 2'b11 : keep;
    for (int k = 0; k <= len; k++) begin
      e.data = base + DW'(k);
      e.keep = (k == len) ? kfix : 2'b11;
      e.last = (k == len);
      e.user = user;
      sb.push_back(e);
    end
    issue_cmd(len, keep, user);
    i = 0;
    cycles = 0;
    while (i <= len && cycles < len * 4 + 50) begin
      s_valid = 1'b1;
      s_data = base + DW'(i);
      rdy = s_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (rdy) i++;
    end
    s_valid = 1'b0;
    exp_frames++;
    check("beats_accepted", 64'(i), 64'(len + 1));
    if (full_rate) check("full_rate_cycles", 64'(cycles), 64'(len + 1));
    check("cmd_ready_after_last", 64'(cmd_ready), 64'(1));
    check("s_ready_after_last", 64'(s_ready), 64'(0));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || m_tvalid) && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("frame_count", 64'(frame_count), 64'(exp_frames % 16));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_outputs", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    rstn = 1'b1;
    check("cmd_ready_before_edge", 64'(cmd_ready), 64'(0));
    @(posedge clk);
    #1;
    check("cmd_ready_after_release", 64'(cmd_ready), 64'(1));

    // Four-beat frame at full rate, keep_last=1.
    hs_cyc.delete();
    send_frame(3, 2'b01, 1'b1, 16'h00A0, 1'b1);
    drain();
    check("t1_beats_out", 64'(hs_cyc.size()), 64'(4));
    if (hs_cyc.size() == 4) check("t1_consecutive", 64'(hs_cyc[3] - hs_cyc[0]), 64'(3));

    // s_valid while idle must not consume data.
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = 16'hDEAD;
      check("idle_s_ready", 64'(s_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("idle_no_output", 64'(m_tvalid), 64'(0));

    // Single-beat frame with keep_last=0.
    send_frame(0, 2'b00, 1'b0, 16'h0B00, 1'b1);
    drain();

    // Eight beats with toggling downstream ready.
    tready_mode = 1;
    send_frame(7, 2'b10, 1'b1, 16'h0C10, 1'b0);
    drain();
    tready_mode = 0;
    @(posedge clk);
    #1;

    // Back-to-back frames, len 1 then len 2.
    send_frame(1, 2'b11, 1'b0, 16'h0D00, 1'b1);
    send_frame(2, 2'b01, 1'b1, 16'h0D10, 1'b1);
    drain();

    // Reset after beat 2 of a six-beat frame.
    begin
      exp_t e;
      e.data = 16'h0E00;
      e.keep = 2'b11;
      e.last = 1'b0;
      e.user = 1'b1;
      sb.push_back(e);
      issue_cmd(5, 2'b11, 1'b1);
      for (int k = 0; k < 2; k++) begin
        s_valid = 1'b1;
        s_data = 16'h0E00 + DW'(k);
        check("mid_s_ready", 64'(s_ready), 64'(1));
        @(posedge clk);
        #1;
      end
      s_valid = 1'b0;
      check("mid_tvalid_before_rst", 64'(m_tvalid), 64'(1));
      rstn = 1'b0;
      #1;
      check("mid_tvalid_async", 64'(m_tvalid), 64'(0));
      check("mid_busy", 64'(busy), 64'(0));
      exp_frames = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      check("mid_cmd_ready_low", 64'(cmd_ready), 64'(0));
      @(posedge clk);
      #1;
      check("mid_cmd_ready_high", 64'(cmd_ready), 64'(1));
      check("mid_frame_count", 64'(frame_count), 64'(0));
      check("mid_sb_empty", 64'(sb.size()), 64'(0));
    end

    // Sixteen one-beat frames wrap the 4-bit frame counter to 0.
    for (int f = 0; f < 16; f++) begin
      send_frame(0, 2'b01, 1'b0, DW'(16'h0F00 + f), 1'b1);
      drain();
    end
    check("wrap_frame_count", 64'(frame_count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
